// File: rtl/jtag_shift_engine.sv
// jtag_shift_engine: streams TMS/TDI words onto the JTAG pins with a programmable TCK
// half-period and returns captured TDO words. Optional define JTAG_SHIFT_LOOPBACK_EN adds loopback_i.
module jtag_shift_engine #(
  parameter int VEC_W = 32,
  parameter int LEN_W = 32,
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [DIV_W-1:0] cmd_half_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [VEC_W-1:0] tms_word_i,
  input  logic [VEC_W-1:0] tdi_word_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [VEC_W-1:0] tdo_word_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             tck_o,
  output logic             tms_o,
  output logic             tdi_o,
`ifdef JTAG_SHIFT_LOOPBACK_EN
  input  logic             loopback_i,
`endif
  input  logic             tdo_i
);

  localparam int IDX_W = $clog2(VEC_W);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TCKL, S_TCKH, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] half_q, half_d, cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nx;
  logic [VEC_W-1:0] tms_sr_q, tms_sr_d, tdi_sr_q, tdi_sr_d;
  logic [VEC_W-1:0] cap_q, cap_d, out_q, out_d;
  logic             out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
  logic             tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic             cap_bit, out_free, rem_last;

`ifdef JTAG_SHIFT_LOOPBACK_EN
  assign cap_bit = loopback_i ? tdi_q : tdo_i;
`else
  assign cap_bit = tdo_i;
`endif

  // The output register is free if empty or being taken this very cycle.
  assign out_free    = !out_valid_q || out_ready_i;
  assign cmd_ready_o = (state_q == S_IDLE) && !busy_q;
  assign in_ready_o  = (state_q == S_LOAD) && out_free;
  assign idx_nx      = idx_q + IDX_W'(1);
  assign rem_last    = (rem_q == LEN_W'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    rem_d       = rem_q;
    half_d      = half_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tms_sr_d    = tms_sr_q;
    tdi_sr_d    = tdi_sr_q;
    cap_d       = cap_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready_i;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;

    unique case (state_q)
      S_IDLE: begin
        // busy lingers one cycle so it overlaps the done pulse.
        busy_d = 1'b0;
        if (cmd_valid_i && cmd_ready_o) begin
          busy_d = 1'b1;
          rem_d  = cmd_len_i;
          half_d = (cmd_half_i == '0) ? DIV_W'(1) : cmd_half_i;
          if (cmd_len_i == '0) done_d  = 1'b1;
          else                 state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid_i && in_ready_o) begin
          tms_sr_d = tms_word_i;
          tdi_sr_d = tdi_word_i;
          cap_d    = '0;
          idx_d    = '0;
          tms_d    = tms_word_i[0];
          tdi_d    = tdi_word_i[0];
          cnt_d    = half_q - DIV_W'(1);
          state_d  = S_TCKL;
        end
      end
      S_TCKL: begin
        if (cnt_q == '0) begin
          tck_d        = 1'b1;
          cap_d[idx_q] = cap_bit;
          cnt_d        = half_q - DIV_W'(1);
          state_d      = S_TCKH;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_TCKH: begin
        if (cnt_q == '0) begin
          tck_d = 1'b0;
          rem_d = rem_q - LEN_W'(1);
          if (rem_last) begin
            out_d       = cap_q;
            out_valid_d = 1'b1;
            state_d     = S_DRAIN;
          end else if (idx_q == IDX_W'(VEC_W - 1)) begin
            out_d       = cap_q;
            out_valid_d = 1'b1;
            state_d     = S_LOAD;
          end else begin
            idx_d   = idx_nx;
            tms_d   = tms_sr_q[idx_nx];
            tdi_d   = tdi_sr_q[idx_nx];
            cnt_d   = half_q - DIV_W'(1);
            state_d = S_TCKL;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_free) begin
          done_d  = 1'b1;
          tms_d   = 1'b0;
          tdi_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the word-wide shift/capture registers are flops, not RAM, so they are reset
  // too; this keeps tdo_word_o at zero after reset and costs nothing in timing.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      half_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      tms_sr_q    <= '0;
      tdi_sr_q    <= '0;
      cap_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      rem_q       <= rem_d;
      half_q      <= half_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tms_sr_q    <= tms_sr_d;
      tdi_sr_q    <= tdi_sr_d;
      cap_q       <= cap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign tdo_word_o  = out_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Self-checking bench for jtag_shift_engine: directed table, reset abort, randomized
// commands compared against a bit-level reference model of the shift stream.
module tb_jtag_shift_engine;

  localparam int VEC_W = 32;
  localparam int LEN_W = 32;
  localparam int DIV_W = 8;
  localparam int MAXW  = 8;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_len_i;
  logic [DIV_W-1:0] cmd_half_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [VEC_W-1:0] tms_word_i;
  logic [VEC_W-1:0] tdi_word_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [VEC_W-1:0] tdo_word_o;
  logic             done_o;
  logic             busy_o;
  logic             tck_o;
  logic             tms_o;
  logic             tdi_o;
  logic             tdo_i;
`ifdef JTAG_SHIFT_LOOPBACK_EN
  logic             loopback_i = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Target model: 0 echoes TDI, 1 returns ~(TDI^TMS), 2 holds TDO low.
  int tdo_mode = 0;
  bit lb = 1'b0;
  assign tdo_i = (tdo_mode == 0) ? tdi_o : (tdo_mode == 1) ? ~(tdi_o ^ tms_o) : 1'b0;

  jtag_shift_engine #(.VEC_W(VEC_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_len_i   (cmd_len_i),
    .cmd_half_i  (cmd_half_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .tms_word_i  (tms_word_i),
    .tdi_word_i  (tdi_word_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .tdo_word_o  (tdo_word_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .tck_o       (tck_o),
    .tms_o       (tms_o),
    .tdi_o       (tdi_o),
`ifdef JTAG_SHIFT_LOOPBACK_EN
    .loopback_i  (loopback_i),
`endif
    .tdo_i       (tdo_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          len;
    int          half;
    int          mode;
    int          bp;
    logic [31:0] tms0;
    logic [31:0] tdi0;
    int          exp_words;
    int          exp_rises;
    logic [31:0] exp_w0;
  } vec_t;

  logic [VEC_W-1:0] tms_w [MAXW];
  logic [VEC_W-1:0] tdi_w [MAXW];
  logic [VEC_W-1:0] exp_w [MAXW];
  int               r_rises, r_in, r_out, r_done, r_pin, r_tim, r_stall, r_stall_seen;
  logic [VEC_W-1:0] r_first;

  function automatic logic model_bit(input int k);
    logic t, d;
    t = tms_w[k / VEC_W][k % VEC_W];
    d = tdi_w[k / VEC_W][k % VEC_W];
    if (lb) return d;
    case (tdo_mode)
      0:       return d;
      1:       return ~(t ^ d);
      default: return 1'b0;
    endcase
  endfunction

  task automatic pulse_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  // Runs one command end to end, checking pins, words and done timing on the fly.
  task automatic run_cmd(input int len, input int half, input int mode, input int bp,
                         input bit rnd, input logic [31:0] tms0, input logic [31:0] tdi0);
    int   n_words, eff, budget, c, hs_c, done_c, ptr, bp_left, run, high_cnt;
    logic p_tck, p_tms, p_tdi, p_ov, p_ohs, in_hs, out_hs;
    n_words  = (len + VEC_W - 1) / VEC_W;
    eff      = (half == 0) ? 1 : half;
    budget   = 4 * len * eff + bp + 200;
    tdo_mode = mode;
    for (int i = 0; i < MAXW; i++) begin
      tms_w[i] = $urandom;
      tdi_w[i] = $urandom;
      exp_w[i] = '0;
    end
    tms_w[0] = tms0;
    tdi_w[0] = tdi0;
    for (int k = 0; k < len; k++) exp_w[k / VEC_W][k % VEC_W] = model_bit(k);
    r_rises = 0; r_in = 0; r_out = 0; r_done = 0; r_pin = 0; r_tim = 0;
    r_stall = 0; r_stall_seen = 0; r_first = '0;
    ptr = 0; bp_left = bp; hs_c = 0; done_c = -1; run = 0; high_cnt = 0;

    @(negedge clk_i);
    check("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_len_i   = LEN_W'(len);
    cmd_half_i  = DIV_W'(half);
    #4;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check("busy_after_accept", busy_o, 1);
    p_tck = tck_o; p_tms = tms_o; p_tdi = tdi_o; p_ov = out_valid_o; p_ohs = 1'b0;
    c = 1;
    while (c <= budget) begin
      if (done_c >= 0) begin
        check("post_done", {done_o, busy_o, cmd_ready_o}, 3'b001);
        break;
      end
      if (done_o) begin
        r_done++;
        done_c = c;
        check("done_timing", c, hs_c + 1);
      end
      run = (tms_o == p_tms && tdi_o == p_tdi) ? run + 1 : 1;
      if (tck_o && !p_tck) begin
        if (run < eff + 1) r_tim++;
        if (r_rises >= len) r_pin++;
        else if (tms_o !== tms_w[r_rises / VEC_W][r_rises % VEC_W] ||
                 tdi_o !== tdi_w[r_rises / VEC_W][r_rises % VEC_W]) r_pin++;
        r_rises++;
      end
      if (!tck_o && p_tck) begin
        if (high_cnt != eff) r_tim++;
        high_cnt = 0;
      end
      if (tck_o) high_cnt++;
      if (out_valid_o && p_ov && !p_ohs && (tck_o || tms_o != p_tms || tdi_o != p_tdi))
        r_stall++;
      p_tck = tck_o; p_tms = tms_o; p_tdi = tdi_o; p_ov = out_valid_o;

      if (ptr >= n_words) in_valid_i = 1'b0;
      else if (!in_valid_i) in_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tms_word_i = tms_w[ptr];
      tdi_word_i = tdi_w[ptr];
      if (bp_left > 0 && out_valid_o) begin
        out_ready_i = 1'b0;
        bp_left--;
        r_stall_seen++;
      end else begin
        out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #4;
      in_hs  = in_valid_i && in_ready_o;
      out_hs = out_valid_o && out_ready_i;
      if (in_hs) begin
        ptr++;
        r_in++;
      end
      if (out_hs) begin
        if (r_out == 0) r_first = tdo_word_o;
        if (r_out < n_words) check($sformatf("out_word%0d", r_out), tdo_word_o, exp_w[r_out]);
        r_out++;
        hs_c = c;
      end
      if (out_hs && in_valid_i && !in_ready_o) r_stall++;
      p_ohs = out_hs;
      @(negedge clk_i);
      c++;
    end
    check("done_count", r_done, 1);
    check("tck_rises", r_rises, len);
    check("in_words", r_in, n_words);
    check("out_words", r_out, n_words);
    check("pin_bits", r_pin, 0);
    check("tck_timing", r_tim, 0);
    check("stall_hold", r_stall, 0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    if (r_done != 1) pulse_reset();
  endtask

  vec_t vecs [8];

  initial begin
    int tck_seen, done_seen;
    vecs[0] = '{8,  2, 0, 0,  32'h0000_00A5, 32'h0000_003C, 1, 8,  32'h0000_003C};
    vecs[1] = '{70, 1, 0, 0,  32'h5555_AAAA, 32'h1234_5678, 3, 70, 32'h1234_5678};
    vecs[2] = '{40, 1, 1, 50, 32'hFFFF_0000, 32'h0F0F_0F0F, 2, 40, 32'h0F0F_F0F0};
    vecs[3] = '{0,  1, 0, 0,  32'h0,         32'h0,         0, 0,  32'h0};
    vecs[4] = '{0,  0, 0, 0,  32'h0,         32'h0,         0, 0,  32'h0};
    vecs[5] = '{32, 0, 0, 0,  32'h8765_4321, 32'hCAFE_F00D, 1, 32, 32'hCAFE_F00D};
    vecs[6] = '{33, 3, 1, 0,  32'h0,         32'h0,         2, 33, 32'hFFFF_FFFF};
    vecs[7] = '{1,  2, 0, 0,  32'h0,         32'hFFFF_FFFF, 1, 1,  32'h0000_0001};

    reset_n_i   = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_len_i   = '0;
    cmd_half_i  = '0;
    in_valid_i  = 1'b0;
    tms_word_i  = '0;
    tdi_word_i  = '0;
    out_ready_i = 1'b1;
    #1;
    check("reset_ctrl", {cmd_ready_o, busy_o, in_ready_o, out_valid_o, done_o, tck_o, tms_o, tdi_o},
          8'b1000_0000);
    check("reset_tdo_word", tdo_word_o, 0);
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;

    // Abort a len=40, H=3 command mid-shift with an asynchronous reset.
    @(negedge clk_i);
    tdo_mode    = 0;
    cmd_valid_i = 1'b1;
    cmd_len_i   = 40;
    cmd_half_i  = 3;
    in_valid_i  = 1'b1;
    tms_word_i  = $urandom;
    tdi_word_i  = $urandom;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    tck_seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (tck_o) tck_seen++;
    end
    check("abort_midshift_busy", busy_o, 1);
    check("abort_midshift_tck_active", tck_seen > 0, 1);
    #2;
    reset_n_i  = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check("abort_ctrl", {cmd_ready_o, busy_o, in_ready_o, out_valid_o, done_o, tck_o, tms_o, tdi_o},
          8'b1000_0000);
    check("abort_tdo_word", tdo_word_o, 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) done_seen++;
    end
    reset_n_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_idle_after", {cmd_ready_o, busy_o, out_valid_o}, 3'b100);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].len, vecs[i].half, vecs[i].mode, vecs[i].bp, 1'b0,
              vecs[i].tms0, vecs[i].tdi0);
      check($sformatf("vec%0d_out_words", i), r_out, vecs[i].exp_words);
      check($sformatf("vec%0d_rises", i), r_rises, vecs[i].exp_rises);
      check($sformatf("vec%0d_stall_cycles", i), r_stall_seen, vecs[i].bp);
      if (vecs[i].exp_words > 0) check($sformatf("vec%0d_first_word", i), r_first, vecs[i].exp_w0);
    end

`ifdef JTAG_SHIFT_LOOPBACK_EN
    lb         = 1'b1;
    loopback_i = 1'b1;
    run_cmd(32, 2, 2, 0, 1'b0, $urandom, 32'hDEAD_BEEF);
    check("loopback_word", r_first, 32'hDEAD_BEEF);
    lb         = 1'b0;
    loopback_i = 1'b0;
`endif

    for (int n = 0; n < 12; n++) begin
      run_cmd($urandom_range(0, 100), $urandom_range(0, 3), $urandom_range(0, 1), 0, 1'b1,
              $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
